// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared digit type, digit limits and display constants for the stopwatch datapath.
package stopwatch_pkg;
    typedef logic [3:0] bcd_t;
    localparam bcd_t DIG_MAX_S1 = 4'd5;
    localparam bcd_t DIG_MAX = 4'd9;
    localparam logic [3:0] AN_IDLE = 4'b1110;
    typedef enum logic [1:0] {IDX_S0, IDX_S1, IDX_M0, IDX_M1} dig_idx_t;
endpackage

// File: rtl/stopwatch_timebase_ctrl_bcd_digit.sv
// bcd_digit: one modulo-(MAX+1) up/down BCD digit; co flags the carry/borrow terminal state.
module bcd_digit import stopwatch_pkg::*; #(
    parameter bcd_t MAX = DIG_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic up,
    input  logic clr,
    output bcd_t q,
    output logic co
);
    bcd_t nxt;
    // Out-of-range values resolve in one step: up wraps to 0 with carry, down lands on MAX without borrow.
    assign co = up ? (q >= MAX) : (q == 4'd0);
    always_comb nxt = up ? (co ? 4'd0 : q + 4'd1) : ((q == 4'd0 || q > MAX) ? MAX : q - 4'd1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            q <= 4'd0;
        else if (clr)
            q <= 4'd0;
        else if (en)
            q <= nxt;
endmodule

// File: rtl/stopwatch_timebase_ctrl.sv
// stopwatch_timebase_ctrl: 1 Hz prescaler, BCD MM:SS up/down counter with wrap pulse, and digit scan.
module stopwatch_timebase_ctrl import stopwatch_pkg::*; #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_up,
    input  logic        paused,
    input  logic        clear,
    output logic [15:0] time_bcd,
    output logic        tick,
    output logic        wrapped,
    output logic [3:0]  an,
    output logic [3:0]  seg_digit
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    logic [PW-1:0] pc;
    logic [SW-1:0] sc;
    dig_idx_t      idx;
    logic [3:0]    co;
    logic [3:0]    en;
    logic          scan_end;
    assign tick = !paused && !clear && pc == PW'(TICK_DIV - 1);
    assign en = {tick & (&co[2:0]), tick & (&co[1:0]), tick & co[0], tick};
    assign scan_end = sc == SW'(SCAN_DIV - 1);
    assign seg_digit = time_bcd[{idx, 2'b00} +: 4];
    for (genvar i = 0; i < 4; i++) begin : g_dig
        bcd_digit #(.MAX(i == 1 ? DIG_MAX_S1 : DIG_MAX)) u_dig (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en[i]),
            .up   (count_up),
            .clr  (clear),
            .q    (time_bcd[4*i +: 4]),
            .co   (co[i])
        );
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc      <= '0;
            wrapped <= 1'b0;
        end else begin
            pc      <= clear ? '0 : paused ? pc : tick ? '0 : pc + 1'b1;
            wrapped <= tick & (&co);
        end
    // The scan runs regardless of pause/clear so the display never freezes on one digit.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sc  <= '0;
            idx <= IDX_S0;
            an  <= AN_IDLE;
        end else begin
            sc  <= scan_end ? '0 : sc + 1'b1;
            idx <= scan_end ? dig_idx_t'(idx + 2'd1) : idx;
            an  <= scan_end ? {an[2:0], an[3]} : an;
        end
endmodule

// File: tb/tb_stopwatch_timebase_ctrl.sv
// tb_stopwatch_timebase_ctrl: scenario tasks plus a seconds-based reference model feeding a time scoreboard.
module tb_stopwatch_timebase_ctrl;
    localparam int TD = 4;
    localparam int SD = 2;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        count_up = 1;
    logic        paused = 0;
    logic        clear = 0;
    logic [15:0] time_bcd;
    logic        tick;
    logic        wrapped;
    logic [3:0]  an;
    logic [3:0]  seg_digit;
    int n_chk = 0;
    int n_fail = 0;
    int          m_pc;
    logic [15:0] m_t;
    logic        m_tick;
    logic [16:0] m_nx;
    logic [16:0] sb[$];

    stopwatch_timebase_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .count_up(count_up), .paused(paused), .clear(clear),
        .time_bcd(time_bcd), .tick(tick), .wrapped(wrapped), .an(an), .seg_digit(seg_digit)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] step(input logic [15:0] t, input logic up);
        int s;
        logic w;
        s = (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
        w = up ? (s == 5999) : (s == 0);
        s = up ? (s + 1) % 6000 : (s + 5999) % 6000;
        return {w, 4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    assign m_tick = !paused && !clear && m_pc == TD - 1;
    assign m_nx = step(m_t, count_up);

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_pc <= 0;
            m_t  <= 16'h0000;
            sb.delete();
        end else if (clear) begin
            m_pc <= 0;
            m_t  <= 16'h0000;
        end else if (!paused) begin
            m_pc <= (m_pc == TD - 1) ? 0 : m_pc + 1;
            if (m_pc == TD - 1) begin
                m_t <= m_nx[15:0];
                sb.push_back(m_nx);
            end
        end

    always @(negedge clk)
        if (rst_n) begin
            n_chk++;
            if (tick !== m_tick) begin
                n_fail++;
                $display("FAIL mon_tick: got %b expected %b at %0t", tick, m_tick, $time);
            end
            if (sb.size() > 0) begin
                logic [16:0] e;
                e = sb.pop_front();
                n_chk++;
                if (time_bcd !== e[15:0]) begin
                    n_fail++;
                    $display("FAIL sb_time: got %h expected %h at %0t", time_bcd, e[15:0], $time);
                end
                n_chk++;
                if (wrapped !== e[16]) begin
                    n_fail++;
                    $display("FAIL sb_wrapped: got %b expected %b at %0t", wrapped, e[16], $time);
                end
            end else begin
                n_chk++;
                if (time_bcd !== m_t || wrapped !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mon_hold: got %h/%b expected %h/0 at %0t", time_bcd, wrapped, m_t, $time);
                end
            end
        end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int n);
        for (int j = 0; j < n; j++) begin
            int k = 0;
            @(negedge clk);
            while (tick !== 1'b1 && k < 40) begin
                @(negedge clk);
                k++;
            end
            n_chk++;
            if (k >= 40) begin
                n_fail++;
                $display("FAIL tick_timeout: got no tick expected tick within 40 cycles");
            end
            cyc();
        end
    endtask

    task automatic do_clear();
        clear = 1;
        cyc();
        clear = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; count_up = 1; paused = 0; clear = 0;
        repeat (3) cyc();
        @(negedge clk);
        n_chk++;
        if (time_bcd !== 16'h0000 || an !== 4'b1110 || tick !== 1'b0 || wrapped !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %h/%b/%b/%b expected 0000/1110/0/0", time_bcd, an, tick, wrapped);
        end
        cyc();
        rst_n = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (tick !== (k == 4)) begin
                n_fail++;
                $display("FAIL reset_tick_c%0d: got %b expected %b", k, tick, k == 4);
            end
        end
        n_chk++;
        if (time_bcd !== 16'h0001) begin
            n_fail++;
            $display("FAIL reset_first_step: got %h expected 0001", time_bcd);
        end
    endtask

    task automatic test_carry();
        count_up = 1;
        do_clear();
        wait_tick(59);
        @(negedge clk);
        n_chk++;
        if (time_bcd !== 16'h0059) begin
            n_fail++;
            $display("FAIL carry_0059: got %h expected 0059", time_bcd);
        end
        wait_tick(1);
        @(negedge clk);
        n_chk++;
        if (time_bcd !== 16'h0100) begin
            n_fail++;
            $display("FAIL carry_0100: got %h expected 0100", time_bcd);
        end
        wait_tick(539);
        @(negedge clk);
        n_chk++;
        if (time_bcd !== 16'h0959) begin
            n_fail++;
            $display("FAIL carry_0959: got %h expected 0959", time_bcd);
        end
        wait_tick(1);
        @(negedge clk);
        n_chk++;
        if (time_bcd !== 16'h1000) begin
            n_fail++;
            $display("FAIL carry_1000: got %h expected 1000", time_bcd);
        end
    endtask

    task automatic test_wrap();
        do_clear();
        count_up = 0;
        wait_tick(1);
        @(negedge clk);
        n_chk++;
        if (time_bcd !== 16'h9959 || wrapped !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_down: got %h/%b expected 9959/1", time_bcd, wrapped);
        end
        @(negedge clk);
        n_chk++;
        if (wrapped !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_down_pulse: got %b expected 0", wrapped);
        end
        count_up = 1;
        wait_tick(1);
        @(negedge clk);
        n_chk++;
        if (time_bcd !== 16'h0000 || wrapped !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_up: got %h/%b expected 0000/1", time_bcd, wrapped);
        end
        @(negedge clk);
        n_chk++;
        if (wrapped !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_up_pulse: got %b expected 0", wrapped);
        end
    endtask

    task automatic test_pause();
        count_up = 1;
        do_clear();
        cyc();
        cyc();
        paused = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_chk++;
            if (tick !== 1'b0 || time_bcd !== 16'h0000) begin
                n_fail++;
                $display("FAIL pause_hold_%0d: got %b/%h expected 0/0000", k, tick, time_bcd);
            end
            cyc();
        end
        paused = 0;
        @(negedge clk);
        n_chk++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_release0: got %b expected 0", tick);
        end
        @(negedge clk);
        n_chk++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_release1: got %b expected 1", tick);
        end
        cyc();
    endtask

    task automatic test_clear_collision();
        count_up = 1;
        do_clear();
        wait_tick(59);
        repeat (3) cyc();
        clear = 1;
        @(negedge clk);
        n_chk++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_masks_tick: got %b expected 0", tick);
        end
        cyc();
        clear = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_chk++;
            if (time_bcd !== 16'h0000 || wrapped !== 1'b0 || tick !== (k == 4)) begin
                n_fail++;
                $display("FAIL clear_after_c%0d: got %h/%b/%b expected 0000/0/%b", k, time_bcd, wrapped, tick, k == 4);
            end
        end
        cyc();
    endtask

    task automatic test_scan();
        logic [3:0] exp_dig[4] = '{4'd4, 4'd3, 4'd2, 4'd1};
        logic [3:0] prev_an;
        int k = 0;
        count_up = 1;
        do_clear();
        wait_tick(754);
        paused = 1;
        @(negedge clk);
        prev_an = an;
        @(negedge clk);
        while (!(an === 4'b1110 && prev_an === 4'b0111) && k < 20) begin
            prev_an = an;
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (k >= 20) begin
            n_fail++;
            $display("FAIL scan_sync: got an %b expected start of 1110 phase", an);
        end
        for (int i = 0; i < 8; i++) begin
            logic [3:0] ea;
            ea = ~(4'b0001 << (i / 2));
            n_chk++;
            if (an !== ea || seg_digit !== exp_dig[i / 2] || time_bcd !== 16'h1234) begin
                n_fail++;
                $display("FAIL scan_%0d: got an %b seg %h time %h expected an %b seg %h time 1234", i, an, seg_digit, time_bcd, ea, exp_dig[i / 2]);
            end
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (an !== 4'b1101) begin
            n_fail++;
            $display("FAIL scan_mid: got %b expected 1101", an);
        end
        #1 rst_n = 0;
        #1;
        n_chk++;
        if (an !== 4'b1110 || time_bcd !== 16'h0000 || tick !== 1'b0 || wrapped !== 1'b0 || seg_digit !== 4'h0) begin
            n_fail++;
            $display("FAIL scan_reset: got %b/%h/%b/%b/%h expected 1110/0000/0/0/0", an, time_bcd, tick, wrapped, seg_digit);
        end
        paused = 0;
        cyc();
        rst_n = 1;
        repeat (3) cyc();
    endtask

    initial begin
        test_reset();
        test_carry();
        test_wrap();
        test_pause();
        test_clear_collision();
        test_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
